axis_pkt_checker: RTL and testbench

- Synthesizable AXI4-Stream sink that sits at the read side of the FIFO under test.
- It is the consumer counterpart to the packet source that writes the FIFO.
- Per beat it applies LFSR-driven tready backpressure, checks payload bytes against a deterministic incrementing pattern, and checks tkeep/tlast framing.
- It accumulates packet, beat and error statistics and captures the first error for bench or ILA readout.

---
 rtl/axis_pkt_checker_pkg.sv | 34 +++
 rtl/axis_pkt_checker_lfsr.sv | 32 +++
 rtl/axis_pkt_checker.sv | 154 +++++++++++++++
 tb/tb_axis_pkt_checker.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_pkt_checker_pkg.sv
// Shared types and helpers for the AXI4-Stream packet checker.
// Holds the FSM/error encodings, the LFSR feedback mask and the payload pattern.
package axis_pkt_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FIRST = 2'd1,
        ST_MID   = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        ERR_NONE = 3'd0,
        ERR_DATA = 3'd1,
        ERR_KEEP = 3'd2,
        ERR_LEN  = 3'd3
    } err_code_t;

    // Right-shifting Galois form of x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_POLY = 16'hB400;

    // Byte 'lane' of beat 'beat' in packet 'pkt' for a bus 'width' bits wide
    function automatic logic [7:0] expected_byte(
        input logic [31:0] pkt,
        input logic [31:0] beat,
        input logic [31:0] lane,
        input logic [31:0] width
    );
        logic [31:0] sum;
        sum = pkt + beat * (width >> 3) + lane;
        return sum[7:0];
    endfunction

endpackage

// File: rtl/axis_pkt_checker_lfsr.sv
// 16-bit Galois LFSR that steps only when advance is high.
// Exposes the low OUT_BITS of the state to keep the consumer interface narrow.
module axis_pkt_checker_lfsr
    import axis_pkt_checker_pkg::*;
#(
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          OUT_BITS = 16
) (
    input  logic                clk,
    input  logic                srst,
    input  logic                advance,
    output logic [OUT_BITS-1:0] value
);

    logic [15:0] lfsr_reg;
    logic [15:0] lfsr_next;

    always_comb begin
        lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_POLY : 16'h0000);
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            lfsr_reg <= SEED;
        end else if (advance) begin
            lfsr_reg <= lfsr_next;
        end
    end

    assign value = lfsr_reg[OUT_BITS-1:0];

endmodule

// File: rtl/axis_pkt_checker.sv
// AXI4-Stream sink: LFSR-paced tready, incrementing-pattern payload check,
// tkeep/tlast framing check, statistics and first-error capture.
module axis_pkt_checker
    import axis_pkt_checker_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int          MAX_BEATS  = 256,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic                    cfg_enable,
    input  logic [3:0]              cfg_ready_thresh,
    input  logic                    cfg_stop_on_err,
    output logic [31:0]             pkt_count,
    output logic [31:0]             beat_count,
    output logic [15:0]             err_count,
    output logic                    err_flag,
    output logic [2:0]              err_code,
    output logic [31:0]             err_pkt_idx,
    output logic [15:0]             err_beat_idx
);

    localparam int NB = DATA_WIDTH / 8;

    state_t      state_reg, state_next;
    logic        tready_reg, tready_next;
    logic        lfsr_advance;
    logic [3:0]  lfsr_low;
    logic [15:0] beat_idx_reg;
    logic [31:0] pkt_count_reg, beat_count_reg, err_pkt_idx_reg;
    logic [15:0] err_count_reg, err_beat_idx_reg;
    logic        err_flag_reg;
    err_code_t   err_code_reg, err_code_now;

    logic          accept;
    logic [15:0]   beat_k;
    logic [NB-1:0] lane_bad;
    logic [NB-1:0] keep_plus_one;
    logic          keep_contig, data_err, keep_err, len_err, beat_err, pkt_end;

    axis_pkt_checker_lfsr #(.SEED(LFSR_SEED), .OUT_BITS(4)) u_lfsr (
        .clk     (aclk),
        .srst    (areset),
        .advance (lfsr_advance),
        .value   (lfsr_low)
    );

    assign accept = s_axis_tvalid & tready_reg;
    assign beat_k = (state_reg == ST_MID) ? beat_idx_reg + 16'd1 : 16'd0;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            assign lane_bad[gi] = s_axis_tkeep[gi] &&
                (s_axis_tdata[gi*8 +: 8] !=
                 expected_byte(pkt_count_reg, {16'd0, beat_k}, 32'(gi), 32'(DATA_WIDTH)));
        end
    endgenerate

    // A mask is contiguous from bit 0 exactly when mask & (mask+1) is zero
    assign keep_plus_one = s_axis_tkeep + NB'(1);
    assign keep_contig   = (s_axis_tkeep != '0) && ((s_axis_tkeep & keep_plus_one) == '0);
    assign data_err      = |lane_bad;
    assign keep_err      = s_axis_tlast ? !keep_contig : (s_axis_tkeep != '1);
    assign len_err       = (beat_k == 16'(MAX_BEATS - 1)) && !s_axis_tlast;
    assign beat_err      = data_err | keep_err | len_err;
    assign pkt_end       = s_axis_tlast | len_err;

    always_comb begin
        if (len_err)       err_code_now = ERR_LEN;
        else if (keep_err) err_code_now = ERR_KEEP;
        else               err_code_now = ERR_DATA;
    end

    always_ff @(posedge aclk) begin
        if (areset) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (cfg_enable) state_next = ST_FIRST;
            ST_FIRST: begin
                if (accept) begin
                    if (beat_err && cfg_stop_on_err) state_next = ST_HALT;
                    else if (!pkt_end)               state_next = ST_MID;
                end else if (!cfg_enable) begin
                    state_next = ST_IDLE;
                end
            end
            ST_MID: begin
                if (accept) begin
                    if (beat_err && cfg_stop_on_err) state_next = ST_HALT;
                    else if (pkt_end)                state_next = ST_FIRST;
                end
            end
            default:  state_next = ST_HALT;
        endcase
    end

    // Threshold 15 needs no special case: any nibble is <= 15
    always_comb begin
        lfsr_advance = (state_reg == ST_FIRST) || (state_reg == ST_MID);
        tready_next  = ((state_next == ST_FIRST) || (state_next == ST_MID)) &&
                       (lfsr_low <= cfg_ready_thresh);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            tready_reg       <= 1'b0;
            beat_idx_reg     <= 16'd0;
            pkt_count_reg    <= 32'd0;
            beat_count_reg   <= 32'd0;
            err_count_reg    <= 16'd0;
            err_flag_reg     <= 1'b0;
            err_code_reg     <= ERR_NONE;
            err_pkt_idx_reg  <= 32'd0;
            err_beat_idx_reg <= 16'd0;
        end else begin
            tready_reg <= tready_next;
            if (accept) begin
                beat_count_reg <= beat_count_reg + 32'd1;
                beat_idx_reg   <= beat_k;
                if (pkt_end) pkt_count_reg <= pkt_count_reg + 32'd1;
                if (beat_err) begin
                    if (err_count_reg != 16'hFFFF) err_count_reg <= err_count_reg + 16'd1;
                    if (!err_flag_reg) begin
                        err_flag_reg     <= 1'b1;
                        err_code_reg     <= err_code_now;
                        err_pkt_idx_reg  <= pkt_count_reg;
                        err_beat_idx_reg <= beat_k;
                    end
                end
            end
        end
    end

    assign s_axis_tready = tready_reg;
    assign pkt_count     = pkt_count_reg;
    assign beat_count    = beat_count_reg;
    assign err_count     = err_count_reg;
    assign err_flag      = err_flag_reg;
    assign err_code      = err_code_reg;
    assign err_pkt_idx   = err_pkt_idx_reg;
    assign err_beat_idx  = err_beat_idx_reg;

endmodule

// File: tb/tb_axis_pkt_checker.sv
// Scoreboard bench for axis_pkt_checker: a packet-level reference model predicts
// per-beat statistics, a monitor compares them and the tready pacing after each edge.
module tb_axis_pkt_checker;

    localparam int DATA_WIDTH = 32;
    localparam int MAX_BEATS  = 256;
    localparam logic [15:0] SEED = 16'hACE1;
    localparam int MAX_WAIT   = 200;

    logic        aclk, areset;
    logic [31:0] s_axis_tdata;
    logic [3:0]  s_axis_tkeep;
    logic        s_axis_tlast, s_axis_tvalid, s_axis_tready;
    logic        cfg_enable, cfg_stop_on_err;
    logic [3:0]  cfg_ready_thresh;
    logic [31:0] pkt_count, beat_count, err_pkt_idx;
    logic [15:0] err_count, err_beat_idx;
    logic        err_flag;
    logic [2:0]  err_code;

    axis_pkt_checker #(.DATA_WIDTH(DATA_WIDTH), .MAX_BEATS(MAX_BEATS), .LFSR_SEED(SEED)) dut (
        .aclk(aclk), .areset(areset),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .cfg_enable(cfg_enable), .cfg_ready_thresh(cfg_ready_thresh), .cfg_stop_on_err(cfg_stop_on_err),
        .pkt_count(pkt_count), .beat_count(beat_count), .err_count(err_count), .err_flag(err_flag),
        .err_code(err_code), .err_pkt_idx(err_pkt_idx), .err_beat_idx(err_beat_idx)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] pkt;
        logic [31:0] beats;
        logic [15:0] errs;
        logic        flag;
        logic [2:0]  code;
        logic [31:0] pidx;
        logic [15:0] bidx;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   low_cnt = 0;
    bit   tr_chk = 1'b1;
    int   beat_no = 0;

    // Reference model state: where the stream is, packet by packet
    int unsigned r_pkt, r_beats, r_k;
    int          r_errs, r_code, r_bidx;
    int unsigned r_pidx;
    bit          r_flag, r_in_pkt;

    task automatic summary_and_finish();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic logic [7:0] pat(input int unsigned p, input int unsigned k, input int unsigned b);
        int unsigned s;
        s = p + k * (DATA_WIDTH / 8) + b;
        return 8'(s % 256);
    endfunction

    function automatic logic [31:0] pword(input int unsigned p, input int unsigned k);
        logic [31:0] w;
        for (int b = 0; b < 4; b++) w[8*b +: 8] = pat(p, k, b);
        return w;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic ref_reset();
        r_pkt = 0; r_beats = 0; r_k = 0; r_errs = 0; r_code = 0;
        r_pidx = 0; r_bidx = 0; r_flag = 0; r_in_pkt = 0;
    endtask

    task automatic ref_beat(input logic [31:0] d, input logic [3:0] keep, input logic last);
        int unsigned k;
        bit len_e, keep_e, data_e;
        exp_t e;
        k = r_in_pkt ? r_k + 1 : 0;
        len_e  = (k == MAX_BEATS - 1) && !last;
        keep_e = last ? !(keep inside {4'b0001, 4'b0011, 4'b0111, 4'b1111}) : (keep != 4'b1111);
        data_e = 0;
        for (int b = 0; b < 4; b++)
            if (keep[b] && d[8*b +: 8] != pat(r_pkt, k, b)) data_e = 1;
        if (len_e || keep_e || data_e) begin
            if (r_errs < 65535) r_errs++;
            if (!r_flag) begin
                r_flag = 1;
                r_code = len_e ? 3 : (keep_e ? 2 : 1);
                r_pidx = r_pkt;
                r_bidx = int'(k);
            end
        end
        r_beats++;
        if (last || len_e) begin
            r_pkt++;
            r_in_pkt = 0;
        end else begin
            r_in_pkt = 1;
            r_k = k;
        end
        e.pkt = r_pkt; e.beats = r_beats; e.errs = 16'(r_errs); e.flag = r_flag;
        e.code = 3'(r_code); e.pidx = r_pidx; e.bidx = 16'(r_bidx);
        exp_q.push_back(e);
    endtask

    // Presents one beat from posedge+1 and returns at posedge+1 after its acceptance
    task automatic send_beat(input logic [31:0] d, input logic [3:0] keep, input logic last);
        int waited;
        bit done;
        ref_beat(d, keep, last);
        s_axis_tdata = d; s_axis_tkeep = keep; s_axis_tlast = last; s_axis_tvalid = 1'b1;
        waited = 0; done = 0;
        while (!done) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                @(posedge aclk);
                #1;
                done = 1;
            end else begin
                waited++;
                if (waited > MAX_WAIT) begin
                    checks++; failures++;
                    $display("FAIL accept_timeout: got no tready in %0d cycles expected acceptance", MAX_WAIT);
                    summary_and_finish();
                end
            end
        end
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_pkt(input int unsigned p, input int len, input int cbeat, input logic [3:0] lkeep,
                            input bit gaps);
        logic [31:0] d;
        for (int k = 0; k < len; k++) begin
            if (gaps && $urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge aclk);
                #1;
            end
            d = pword(p, k);
            if (k == cbeat) d[7:0] = d[7:0] ^ 8'h06;
            send_beat(d, (k == len - 1) ? lkeep : 4'hF, k == len - 1);
        end
    endtask

    task automatic drain();
        repeat (3) @(posedge aclk);
        #1;
    endtask

    task automatic do_reset();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        s_axis_tvalid = 1'b0;
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
        ref_reset();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tready"}, {31'd0, s_axis_tready}, 32'd0);
        check({tag, "_pkt_count"}, pkt_count, 32'd0);
        check({tag, "_beat_count"}, beat_count, 32'd0);
        check({tag, "_err_count"}, {16'd0, err_count}, 32'd0);
        check({tag, "_err_flag"}, {31'd0, err_flag}, 32'd0);
        check({tag, "_err_code"}, {29'd0, err_code}, 32'd0);
        check({tag, "_err_pkt_idx"}, err_pkt_idx, 32'd0);
        check({tag, "_err_beat_idx"}, {16'd0, err_beat_idx}, 32'd0);
    endtask

    // Monitor: per-beat statistics one cycle after acceptance, plus tready pacing model
    logic [15:0] m_lf;
    bit          m_act, m_act_after, m_exp_tr, m_pend;
    initial begin
        exp_t e;
        m_lf = SEED; m_act = 0; m_exp_tr = 0; m_pend = 0;
        forever begin
            @(negedge aclk);
            if (m_pend) begin
                m_pend = 0;
                if (exp_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_accept: got beat_count=%0d expected no acceptance", beat_count);
                end else begin
                    e = exp_q.pop_front();
                    beat_no++;
                    $display("beat %0d: pkt=%0d beats=%0d errs=%0d code=%0d", beat_no, pkt_count,
                             beat_count, err_count, err_code);
                    check("pkt_count", pkt_count, e.pkt);
                    check("beat_count", beat_count, e.beats);
                    check("err_count", {16'd0, err_count}, {16'd0, e.errs});
                    check("err_flag", {31'd0, err_flag}, {31'd0, e.flag});
                    check("err_code", {29'd0, err_code}, {29'd0, e.code});
                    check("err_pkt_idx", err_pkt_idx, e.pidx);
                    check("err_beat_idx", {16'd0, err_beat_idx}, {16'd0, e.bidx});
                end
            end
            if (areset) begin
                m_lf = SEED; m_act = 0; m_exp_tr = 0;
            end else begin
                if (tr_chk) begin
                    check("tready_pacing", {31'd0, s_axis_tready}, {31'd0, m_exp_tr});
                    if (m_act && !s_axis_tready) low_cnt++;
                end
                m_act_after = m_act | cfg_enable;
                m_exp_tr = m_act_after && (m_lf[3:0] <= cfg_ready_thresh);
                if (m_act) m_lf = lfsr_step(m_lf);
                m_act = m_act_after;
                if (s_axis_tvalid && s_axis_tready) m_pend = 1;
            end
        end
    end

    initial begin
        #3000000;
        checks++; failures++;
        $display("FAIL watchdog: got simulation still running expected completion");
        summary_and_finish();
    end

    initial begin
        logic [3:0] lk;
        areset = 1'b1; cfg_enable = 1'b0; cfg_ready_thresh = 4'd15; cfg_stop_on_err = 1'b0;
        s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
        ref_reset();
        repeat (3) @(posedge aclk);
        #1 areset = 1'b0;
        @(negedge aclk);
        check_all_zero("reset");

        // Always-ready: three clean 4-beat packets
        @(posedge aclk);
        #1 cfg_enable = 1'b1;
        for (int p = 0; p < 3; p++) send_pkt(p, 4, -1, 4'hF, 0);
        drain();
        check("t1_pkt_count", pkt_count, 32'd3);
        check("t1_beat_count", beat_count, 32'd12);
        check("t1_err_flag", {31'd0, err_flag}, 32'd0);

        // Throttled: 100 clean packets of random length and tail keep
        do_reset();
        cfg_ready_thresh = 4'd7;
        low_cnt = 0;
        for (int p = 0; p < 100; p++) begin
            case ($urandom_range(0, 3))
                0: lk = 4'b0001;
                1: lk = 4'b0011;
                2: lk = 4'b0111;
                default: lk = 4'b1111;
            endcase
            send_pkt(p, $urandom_range(1, 256), -1, lk, 1);
        end
        drain();
        check("t2_pkt_count", pkt_count, 32'd100);
        check("t2_err_count", {16'd0, err_count}, 32'd0);
        check("t2_ready_low_seen", {31'd0, low_cnt > 0}, 32'd1);

        // Data corruption on packet 2, beat 1, byte 0
        do_reset();
        cfg_ready_thresh = 4'd10;
        for (int p = 0; p < 5; p++) send_pkt(p, 3, (p == 2) ? 1 : -1, 4'hF, 0);
        drain();
        check("t3_err_flag", {31'd0, err_flag}, 32'd1);
        check("t3_err_code", {29'd0, err_code}, 32'd1);
        check("t3_err_pkt_idx", err_pkt_idx, 32'd2);
        check("t3_err_beat_idx", {16'd0, err_beat_idx}, 32'd1);
        check("t3_err_count", {16'd0, err_count}, 32'd1);

        // Keep violations, then a legal short tail
        do_reset();
        cfg_ready_thresh = 4'd15;
        send_beat(pword(0, 0), 4'b0111, 1'b0);
        send_beat(pword(0, 1), 4'b0101, 1'b1);
        send_pkt(1, 2, -1, 4'b0011, 0);
        drain();
        check("t4_err_count", {16'd0, err_count}, 32'd2);
        check("t4_err_code", {29'd0, err_code}, 32'd2);
        check("t4_pkt_count", pkt_count, 32'd2);

        // Length overflow: 257 beats, tlast only on the last one
        do_reset();
        cfg_ready_thresh = 4'd12;
        send_pkt(0, 2, -1, 4'hF, 0);
        for (int k = 0; k < 256; k++) send_beat(pword(1, k), 4'hF, 1'b0);
        drain();
        check("t5_pkt_after_resync", pkt_count, 32'd2);
        check("t5_err_code", {29'd0, err_code}, 32'd3);
        check("t5_err_beat_idx", {16'd0, err_beat_idx}, 32'd255);
        check("t5_err_pkt_idx", err_pkt_idx, 32'd1);
        send_beat(pword(2, 0), 4'hF, 1'b1);
        send_pkt(3, 2, -1, 4'hF, 0);
        drain();
        check("t5_pkt_count", pkt_count, 32'd4);
        check("t5_err_count", {16'd0, err_count}, 32'd1);

        // Stop on error: halt after the first bad beat, recover only by reset
        do_reset();
        cfg_stop_on_err = 1'b1;
        tr_chk = 1'b0;
        send_beat(pword(0, 0) ^ 32'h6, 4'hF, 1'b0);
        s_axis_tdata = pword(0, 1); s_axis_tkeep = 4'hF; s_axis_tlast = 1'b1; s_axis_tvalid = 1'b1;
        repeat (10) begin
            @(negedge aclk);
            check("t6_halt_tready", {31'd0, s_axis_tready}, 32'd0);
        end
        check("t6_beat_count", beat_count, 32'd1);
        check("t6_err_code", {29'd0, err_code}, 32'd1);
        check("t6_pkt_count", pkt_count, 32'd0);
        @(posedge aclk);
        #1 cfg_enable = 1'b0;
        do_reset();
        @(negedge aclk);
        check_all_zero("t6_after_reset");
        repeat (3) begin
            @(negedge aclk);
            check("t6_idle_tready", {31'd0, s_axis_tready}, 32'd0);
        end

        summary_and_finish();
    end

endmodule
